// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt sequencer state encoding, status flag
// bit positions and the default vector addresses.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_PUSH_H = 3'd2,
    ST_PUSH_L = 3'd3,
    ST_PUSH_P = 3'd4,
    ST_VEC_L  = 3'd5,
    ST_VEC_H  = 3'd6,
    ST_DONE   = 3'd7
  } irq_state_t;

  // Status register bit positions (bit 5 is the always-one bit).
  localparam int CF = 0;
  localparam int ZF = 1;
  localparam int IF = 2;
  localparam int DF = 3;
  localparam int BF = 4;
  localparam int UF = 5;
  localparam int VF = 6;
  localparam int SF = 7;

  // Default vector addresses, low byte at the address, high byte at +1.
  localparam logic [15:0] NMI_VEC_DEF = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC_DEF = 16'hFFFE;
  localparam logic [15:0] VEC_TBL_DEF = 16'hFFE0;

  localparam logic [7:0] STACK_PAGE = 8'h01;

  // Status byte as pushed by a hardware interrupt: B clear, bit 5 set.
  function automatic logic [7:0] push_flags(input logic [7:0] p);
    logic [7:0] r;
    r     = p;
    r[BF] = 1'b0;
    r[UF] = 1'b1;
    return r;
  endfunction

  // Status byte after entering a handler: further IRQs masked.
  function automatic logic [7:0] set_imask(input logic [7:0] p);
    logic [7:0] r;
    r     = p;
    r[IF] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cpu_irq_arb.sv
// Combinational interrupt arbiter: NMI beats every IRQ, lower IRQ index
// beats higher. Produces the one-hot IRQ winner and its vector address.
module cpu_irq_arb #(
  parameter int          IRQ_N    = 4,
  parameter int          VECTORED = 0,
  parameter logic [15:0] NMI_VEC  = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC  = 16'hFFFE,
  parameter logic [15:0] VEC_TBL  = 16'hFFE0
) (
  input  logic             nmi_req,
  input  logic [IRQ_N-1:0] irq,
  input  logic             i_mask,
  output logic             valid,
  output logic             is_nmi,
  output logic [IRQ_N-1:0] winner,
  output logic [15:0]      vec
);

  logic found;

  // Priority encode the IRQ lines, then let a pending NMI override.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    vec    = IRQ_VEC;
    for (int k = 0; k < IRQ_N; k++) begin
      if (!found && irq[k]) begin
        found     = 1'b1;
        winner[k] = 1'b1;
        if (VECTORED != 0) vec = VEC_TBL + 16'(2 * k);
      end
    end
    is_nmi = nmi_req;
    if (nmi_req) begin
      winner = '0;
      vec    = NMI_VEC;
    end
    valid = nmi_req | (found & ~i_mask);
  end

endmodule

// File: rtl/cpu_irq_seq.sv
// Interrupt entry sequencer. At an opcode-fetch boundary it accepts the
// highest-priority pending source, pushes PCH, PCL and P onto page 01,
// fetches the two vector bytes and hands new PC/S/P to the CPU on done.
//
// Bus handshake: every state advances by exactly one step on each clock
// edge where ce=1. R and W are registered strobes qualified by ce, so a
// bus cycle is performed exactly once per ce cycle it is shown; A and D
// stay stable across ce=0 cycles. I is sampled on the ce edge that ends a
// read cycle.
module cpu_irq_seq
  import cpu_pkg::*;
#(
  parameter int          IRQ_N    = 4,
  parameter int          VECTORED = 0,
  parameter logic [15:0] NMI_VEC  = NMI_VEC_DEF,
  parameter logic [15:0] IRQ_VEC  = IRQ_VEC_DEF,
  parameter logic [15:0] VEC_TBL  = VEC_TBL_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             nmi,
  input  logic [IRQ_N-1:0] irq,
  input  logic             boundary,
  input  logic [15:0]      pc_in,
  input  logic [7:0]       s_in,
  input  logic [7:0]       p_in,
  output logic             take,
  output logic [15:0]      A,
  output logic [7:0]       D,
  input  logic [7:0]       I,
  output logic             R,
  output logic             W,
  output logic [15:0]      pc_out,
  output logic [7:0]       s_out,
  output logic [7:0]       p_out,
  output logic             done,
  output logic [IRQ_N-1:0] irq_ack,
  output logic [2:0]       state_dbg
);

  irq_state_t       state;
  logic             nmi_q;
  logic             nmi_pend;
  logic             take_q;
  logic             done_q;
  logic             r_q;
  logic             w_q;
  logic [IRQ_N-1:0] ack_q;
  logic [IRQ_N-1:0] ack_sel;
  logic             src_nmi;
  logic [15:0]      vec_q;
  logic [15:0]      pc_l;
  logic [7:0]       p_l;
  logic [7:0]       sp;
  logic [7:0]       lo_q;
  logic [15:0]      a_q;
  logic [7:0]       d_q;

  logic             nmi_edge;
  logic             in_window;
  logic             hijack;
  logic             pend_clr;
  logic [15:0]      vec_nxt;

  logic             arb_valid;
  logic             arb_is_nmi;
  logic [IRQ_N-1:0] arb_winner;
  logic [15:0]      arb_vec;

  cpu_irq_arb #(
    .IRQ_N    (IRQ_N),
    .VECTORED (VECTORED),
    .NMI_VEC  (NMI_VEC),
    .IRQ_VEC  (IRQ_VEC),
    .VEC_TBL  (VEC_TBL)
  ) u_arb (
    .nmi_req (nmi_pend | nmi_edge),
    .irq     (irq),
    .i_mask  (p_in[IF]),
    .valid   (arb_valid),
    .is_nmi  (arb_is_nmi),
    .winner  (arb_winner),
    .vec     (arb_vec)
  );

  // NMI edge detect, and the NMI-over-IRQ takeover window before VEC_L.
  always_comb begin
    nmi_edge  = ce & nmi & ~nmi_q;
    in_window = (state == ST_ACC) || (state == ST_PUSH_H) ||
                (state == ST_PUSH_L) || (state == ST_PUSH_P);
    hijack    = nmi_edge & ~src_nmi & in_window;
    pend_clr  = (state == ST_ACC) & src_nmi;
    vec_nxt   = hijack ? NMI_VEC : vec_q;
  end

  // Sequencer FSM with registered bus strobes and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      nmi_q    <= 1'b0;
      nmi_pend <= 1'b0;
      take_q   <= 1'b0;
      done_q   <= 1'b0;
      r_q      <= 1'b0;
      w_q      <= 1'b0;
      ack_q    <= '0;
      ack_sel  <= '0;
      src_nmi  <= 1'b0;
      vec_q    <= '0;
      pc_l     <= '0;
      p_l      <= '0;
      sp       <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      d_q      <= '0;
      pc_out   <= '0;
      s_out    <= '0;
      p_out    <= '0;
    end else if (ce) begin
      nmi_q <= nmi;
      // A takeover consumes the edge; otherwise a new edge outranks the
      // clear that happens as an NMI sequence starts pushing.
      if (hijack)        nmi_pend <= 1'b0;
      else if (nmi_edge) nmi_pend <= 1'b1;
      else if (pend_clr) nmi_pend <= 1'b0;

      r_q    <= 1'b0;
      w_q    <= 1'b0;
      done_q <= 1'b0;
      ack_q  <= '0;

      if (hijack) begin
        src_nmi <= 1'b1;
        ack_sel <= '0;
        vec_q   <= NMI_VEC;
      end

      case (state)
        ST_IDLE: begin
          if (boundary && arb_valid) begin
            state   <= ST_ACC;
            take_q  <= 1'b1;
            src_nmi <= arb_is_nmi;
            ack_sel <= arb_winner;
            vec_q   <= arb_vec;
            pc_l    <= pc_in;
            p_l     <= p_in;
            sp      <= s_in;
          end
        end
        ST_ACC: begin
          state <= ST_PUSH_H;
          a_q   <= {STACK_PAGE, sp};
          d_q   <= pc_l[15:8];
          w_q   <= 1'b1;
          sp    <= sp - 8'd1;
        end
        ST_PUSH_H: begin
          state <= ST_PUSH_L;
          a_q   <= {STACK_PAGE, sp};
          d_q   <= pc_l[7:0];
          w_q   <= 1'b1;
          sp    <= sp - 8'd1;
        end
        ST_PUSH_L: begin
          state <= ST_PUSH_P;
          a_q   <= {STACK_PAGE, sp};
          d_q   <= push_flags(p_l);
          w_q   <= 1'b1;
          sp    <= sp - 8'd1;
        end
        ST_PUSH_P: begin
          state <= ST_VEC_L;
          a_q   <= vec_nxt;
          r_q   <= 1'b1;
        end
        ST_VEC_L: begin
          state <= ST_VEC_H;
          lo_q  <= I;
          a_q   <= vec_q + 16'd1;
          r_q   <= 1'b1;
        end
        ST_VEC_H: begin
          state  <= ST_DONE;
          pc_out <= {I, lo_q};
          p_out  <= set_imask(p_l);
          s_out  <= sp;
          done_q <= 1'b1;
          ack_q  <= ack_sel;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          take_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are only visible in cycles where the CPU clock enable is high.
  always_comb begin
    take      = take_q;
    A         = a_q;
    D         = d_q;
    R         = r_q & ce;
    W         = w_q & ce;
    done      = done_q & ce;
    irq_ack   = ack_q & {IRQ_N{ce}};
    state_dbg = state;
  end

endmodule

// File: tb/tb_cpu_irq_seq.sv
// Directed bench for the interrupt entry sequencer: a vector table of
// single interrupts plus hand-written multi-cycle sequences.
module tb_cpu_irq_seq;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        nmi = 1'b0;
  logic [3:0]  irq = '0;
  logic        boundary = 1'b0;
  logic [15:0] pc_in = '0;
  logic [7:0]  s_in = '0;
  logic [7:0]  p_in = '0;
  logic        take;
  logic [15:0] A;
  logic [7:0]  D;
  logic [7:0]  I;
  logic        R;
  logic        W;
  logic [15:0] pc_out;
  logic [7:0]  s_out;
  logic [7:0]  p_out;
  logic        done;
  logic [3:0]  irq_ack;
  logic [2:0]  state_dbg;

  always #20 clock = ~clock;

  cpu_irq_seq #(.IRQ_N(4), .VECTORED(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .nmi       (nmi),
    .irq       (irq),
    .boundary  (boundary),
    .pc_in     (pc_in),
    .s_in      (s_in),
    .p_in      (p_in),
    .take      (take),
    .A         (A),
    .D         (D),
    .I         (I),
    .R         (R),
    .W         (W),
    .pc_out    (pc_out),
    .s_out     (s_out),
    .p_out     (p_out),
    .done      (done),
    .irq_ack   (irq_ack),
    .state_dbg (state_dbg)
  );

  // Memory model: read data follows the address.
  logic [7:0] mem [0:65535];
  assign I = mem[A];

  // Clock-enable generator: ce high one cycle in every ce_div.
  int ce_div = 1;
  int ce_ph = 0;
  always @(posedge clock) begin
    #5;
    ce_ph = (ce_ph + 1 >= ce_div) ? 0 : ce_ph + 1;
    ce = (ce_ph == 0);
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;
  int bnd_ce = 0;
  int done_ce = 0;
  int done_cnt = 0;
  int rw_viol = 0;
  int ce_viol = 0;
  int ack_viol = 0;
  logic [3:0] cap_ack = '0;

  // Bus monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (W) got_q.push_back({A, D});
    if ((R && W) || (state_dbg == 3'd0 && (R || W))) rw_viol++;
    if (!ce && (R || W || done || irq_ack != 4'b0)) ce_viol++;
    if (irq_ack != 4'b0 && !done) ack_viol++;
    if (boundary && ce) bnd_ce = ce_cnt;
    if (done) begin
      done_cnt++;
      done_ce = ce_cnt;
      cap_ack = irq_ack;
    end
    if (ce) ce_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #6;
  endtask

  task automatic pulse_boundary();
    int n = 0;
    while (ce !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
  endtask

  task automatic set_nmi(input logic v);
    int n = 0;
    nmi = v;
    while (n < 2) begin
      if (ce) n++;
      tick();
    end
  endtask

  task automatic setup_pushes(input logic [7:0] s, input logic [15:0] pc, input logic [7:0] pp);
    logic [7:0] s1;
    logic [7:0] s2;
    s1 = s - 8'd1;
    s2 = s - 8'd2;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({8'h01, s, pc[15:8]});
    exp_q.push_back({8'h01, s1, pc[7:0]});
    exp_q.push_back({8'h01, s2, pp});
  endtask

  task automatic finish_seq(input string nm, input int start, input logic [15:0] epc,
                            input logic [7:0] es, input logic [7:0] ep, input logic [3:0] eack);
    int n = 0;
    while (done_cnt == start && n < 300) begin
      tick();
      n++;
    end
    irq = '0;
    chk({nm, "_done_count"}, 32'(done_cnt - start), 32'd1);
    chk({nm, "_pc_out"}, 32'(pc_out), 32'(epc));
    chk({nm, "_s_out"}, 32'(s_out), 32'(es));
    chk({nm, "_p_out"}, 32'(p_out), 32'(ep));
    chk({nm, "_irq_ack"}, 32'(cap_ack), 32'(eack));
    chk({nm, "_latency"}, 32'(done_ce - bnd_ce), 32'd7);
    chk({nm, "_take_low"}, 32'(take), 32'd0);
    chk({nm, "_wr_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({nm, "_write"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        nmi_src;
    logic [3:0]  irq;
    logic [7:0]  p;
    logic [7:0]  s;
    logic [15:0] pc;
    logic [15:0] exp_pc;
    logic [7:0]  exp_s;
    logic [7:0]  exp_p;
    logic [7:0]  exp_pp;
    logic [3:0]  exp_ack;
  } vec_t;

  vec_t tbl [6];

  task automatic run_vec(input int i);
    vec_t v;
    int start;
    v = tbl[i];
    irq = v.irq;
    p_in = v.p;
    s_in = v.s;
    pc_in = v.pc;
    setup_pushes(v.s, v.pc, v.exp_pp);
    if (v.nmi_src) set_nmi(1'b1);
    start = done_cnt;
    pulse_boundary();
    finish_seq($sformatf("vec%0d", i), start, v.exp_pc, v.exp_s, v.exp_p, v.exp_ack);
    set_nmi(1'b0);
  endtask

  // ---------------- test ----------------
  initial begin
    int start;
    int n;
    logic took;

    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFE0] = 8'h00; mem[16'hFFE1] = 8'hA0;
    mem[16'hFFE2] = 8'h00; mem[16'hFFE3] = 8'hB0;
    mem[16'hFFE4] = 8'h34; mem[16'hFFE5] = 8'h12;
    mem[16'hFFE6] = 8'h78; mem[16'hFFE7] = 8'h56;

    //            nmi   irq      p      s      pc        pc_out    s_out  p_out  pushedP ack
    tbl[0] = '{1'b1, 4'b0000, 8'h24, 8'hFD, 16'hC123, 16'h9000, 8'hFA, 8'h24, 8'h24, 4'b0000};
    tbl[1] = '{1'b0, 4'b1100, 8'h00, 8'hFF, 16'h8000, 16'h1234, 8'hFC, 8'h04, 8'h20, 4'b0100};
    tbl[2] = '{1'b0, 4'b1111, 8'hB3, 8'h01, 16'h4567, 16'hA000, 8'hFE, 8'hB7, 8'hA3, 4'b0001};
    tbl[3] = '{1'b0, 4'b1000, 8'hC8, 8'h80, 16'h0001, 16'h5678, 8'h7D, 8'hCC, 8'hE8, 4'b1000};
    tbl[4] = '{1'b1, 4'b0010, 8'h00, 8'h40, 16'hABCD, 16'h9000, 8'h3D, 8'h04, 8'h20, 4'b0000};
    tbl[5] = '{1'b0, 4'b0110, 8'h10, 8'h10, 16'h2222, 16'hB000, 8'h0D, 8'h14, 8'h20, 4'b0010};

    // Reset state
    repeat (3) tick();
    chk("reset_ctrl", 32'({take, done, R, W, irq_ack, state_dbg}), 32'd0);
    chk("reset_bus", 32'({A, D}), 32'd0);
    chk("reset_regs", {pc_out, s_out, p_out}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Table-driven single interrupts
    for (int i = 0; i < 6; i++) run_vec(i);

    // Masked IRQ is never accepted; unmasking lets it run, and dropping
    // the request right after acceptance still completes on its vector.
    irq = 4'b0001;
    p_in = 8'h04;
    s_in = 8'hFD;
    pc_in = 16'hC123;
    took = 1'b0;
    boundary = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (take) took = 1'b1;
    end
    boundary = 1'b0;
    chk("masked_no_take", 32'(took), 32'd0);
    p_in = 8'h00;
    setup_pushes(8'hFD, 16'hC123, 8'h20);
    start = done_cnt;
    pulse_boundary();
    irq = 4'b0000;
    finish_seq("unmask", start, 16'hA000, 8'hFA, 8'h04, 4'b0001);

    // NMI edge during PUSH_L takes over an accepted IRQ.
    irq = 4'b0100;
    p_in = 8'h00;
    s_in = 8'hFD;
    pc_in = 16'h3000;
    setup_pushes(8'hFD, 16'h3000, 8'h20);
    start = done_cnt;
    pulse_boundary();
    n = 0;
    while (state_dbg != ST_PUSH_L && n < 50) begin
      tick();
      n++;
    end
    chk("hijack_reach_push_l", 32'(state_dbg), 32'(ST_PUSH_L));
    nmi = 1'b1;
    finish_seq("hijack", start, 16'h9000, 8'hFA, 8'h04, 4'b0000);
    start = done_cnt;
    pulse_boundary();
    repeat (30) tick();
    chk("hijack_no_retake", 32'(done_cnt - start), 32'd0);
    set_nmi(1'b0);

    // Same NMI entry with ce high one cycle in three.
    ce_div = 3;
    repeat (6) tick();
    run_vec(0);

    // Reset during PUSH_P aborts with no further bus cycles or done.
    irq = '0;
    p_in = 8'h24;
    s_in = 8'hFD;
    pc_in = 16'hC123;
    set_nmi(1'b1);
    pulse_boundary();
    n = 0;
    while (state_dbg != ST_PUSH_P && n < 100) begin
      tick();
      n++;
    end
    chk("abort_reach_push_p", 32'(state_dbg), 32'(ST_PUSH_P));
    reset = 1'b1;
    got_q.delete();
    #1;
    chk("abort_w_low", 32'(W), 32'd0);
    chk("abort_idle", 32'({take, state_dbg}), 32'd0);
    tick();
    reset = 1'b0;
    nmi = 1'b0;
    start = done_cnt;
    repeat (40) tick();
    chk("abort_no_done", 32'(done_cnt - start), 32'd0);
    chk("abort_no_writes", 32'(got_q.size()), 32'd0);

    // Whole-run bus rules
    chk("r_w_exclusive", 32'(rw_viol), 32'd0);
    chk("strobes_need_ce", 32'(ce_viol), 32'd0);
    chk("ack_only_with_done", 32'(ack_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
